ct_biu_lpmd_resp: RTL and testbench
===================================

// Module: ct_biu_lpmd_resp
// PURPOSE
//  BIU-side responder to the CP0 low-power (WFI) request handshake. On cp0_biu_no_op_req it
//  stops new bus issues, drains outstanding transactions, then returns biu_yy_xx_no_op.
//  It then tracks cp0_biu_lpmd_b to hold the bus quiet during LPMD, and releases on wake-up.
//  Sits between upstream IFU/LSU bus requesters and the BIU bus request port.
// PARAMETERS
//  OUTSTD_W   4     outstanding-transaction counter width; max outstanding = 2^OUTSTD_W-1
//  DRAIN_TMO  1024  drain watchdog limit in cycles (used only with CT_BIU_LPMD_DRAIN_TMO_EN)
// PORTS
//  forever_cpuclk     in   1  ungated CPU clock; sole clock
//  cpurst             in   1  reset, synchronous, active-high
//  cp0_biu_no_op_req  in   1  CP0 request: stop issuing and drain (level)
//  cp0_biu_lpmd_b     in   2  CP0 low-power bits; 2'b11 = run, any other value = LPMD
//  up_req_vld         in   1  upstream bus request valid
//  up_req_rdy         out  1  upstream ready (= bus_req_rdy when issue is allowed)
//  bus_req_vld        out  1  request valid to bus (= up_req_vld when issue is allowed)
//  bus_req_rdy        in   1  bus accepts request
//  bus_resp_last      in   1  final response beat of one transaction
//  biu_yy_xx_no_op    out  1  BIU idle ack to CP0
//  biu_pad_lpmd_b     out  2  registered LPMD bits to SoC
//  biu_lpmd_drain_tmo out  1  drain watchdog pulse (0 when macro is off)
// BEHAVIOUR
//  Reset: state=RUN, cnt=0, biu_yy_xx_no_op=0, biu_pad_lpmd_b=2'b11, biu_lpmd_drain_tmo=0.
//  Issue gating (combinational): allow = (state==RUN) && !cp0_biu_no_op_req && cnt!=MAX.
//    In the cycle no_op_req rises, no new transaction is issued.
//  Issue event: bus_req_vld && bus_req_rdy.
//  Counter: cnt+1 on issue only; cnt-1 on bus_resp_last only; hold when both occur.
//    bus_resp_last at cnt==0 is ignored (no underflow). Issue is blocked at MAX (no overflow).
//  FSM (registered, next-state combinational):
//   RUN   : no_op_req -> DRAIN.
//   DRAIN : !no_op_req (flush) -> RUN; else if cnt==0 && !bus_resp_last -> NOOP;
//           a last response that brings cnt 1->0 gives NOOP one cycle later.
//   NOOP  : !no_op_req -> RUN; else if cp0_biu_lpmd_b!=2'b11 -> SLEEP.
//   SLEEP : cp0_biu_lpmd_b==2'b11 -> RUN, regardless of no_op_req.
//  biu_yy_xx_no_op = registered (state is NOOP or SLEEP). Minimum latency from no_op_req
//    to ack with cnt==0 is 2 cycles.
//  biu_pad_lpmd_b: register loads cp0_biu_lpmd_b on NOOP->SLEEP and loads 2'b11 on
//    SLEEP->RUN; otherwise holds.
//  Wake takes precedence: if lpmd_b==11 and no_op_req are both seen in SLEEP, the FSM goes
//    to RUN, then re-enters DRAIN on the next cycle.
//  Synchronous reset at any point forces reset values; in-flight counts are discarded.
// CONFIGURATION
//  CT_BIU_LPMD_DRAIN_TMO_EN defined:
//   - A timer clears on DRAIN entry and counts each cycle spent in DRAIN.
//   - biu_lpmd_drain_tmo pulses 1 cycle when the timer reaches DRAIN_TMO-1.
//   - The timer saturates after the pulse (single pulse per DRAIN episode); the FSM is not
//     otherwise affected.
//  Undefined: no timer logic; biu_lpmd_drain_tmo tied to 1'b0.
// STRUCTURE
//  ct_biu_lpmd_pkg:
//   - state encodings RUN=2'b00, DRAIN=2'b01, NOOP=2'b10, SLEEP=2'b11
//   - LPMD_RUN_B=2'b11
//  Sub-module ct_biu_lpmd_outstd_cnt:
//   - holds the up/down counter
//   - outputs cnt_zero and cnt_full
//  FSM, gating, ack and pad register live in the top module.
// TESTING
//  1 Idle drain: cnt=0, raise no_op_req at cycle T -> bus_req_vld=0 from T;
//    biu_yy_xx_no_op=1 at T+2.
//  2 Busy drain: 3 issued, no_op_req, resp_last at +5,+8,+12 -> no_op ack 2 cycles after
//    the third response; no new issue during drain.
//  3 Sleep/wake: in NOOP drive lpmd_b=2'b00 -> SLEEP, biu_pad_lpmd_b=00;
//    lpmd_b=11 -> RUN, pad=11, no_op=0, issue resumes.
//  4 Flush: drop no_op_req while in DRAIN with cnt=2 -> RUN next cycle; up_req passes
//    through immediately.
//  5 Counter edges: issue and resp_last in the same cycle -> cnt holds; fill to 15 ->
//    up_req_rdy=0; resp_last at cnt=0 -> cnt stays 0.
//  6 Macro on, DRAIN_TMO=8, no responses for 20 cycles in DRAIN -> one tmo pulse at drain
//    cycle 7; macro off -> tmo stays 0.
//  Also: reset asserted in SLEEP -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ct_biu_lpmd_pkg.sv
// Shared types for the BIU low-power-mode responder.
// Holds FSM state encodings and the LPMD "run" code.
package ct_biu_lpmd_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_NOOP  = 2'b10,
    ST_SLEEP = 2'b11
  } lpmd_st_e;

  localparam logic [1:0] LPMD_RUN_B = 2'b11;

endpackage

// File: rtl/ct_biu_lpmd_resp_if.sv
// Upstream/bus request handshake bundle seen by the LPMD responder.
// slave: the responder; master: requester + bus side.
interface ct_biu_lpmd_resp_if;

  logic up_req_vld;
  logic up_req_rdy;
  logic bus_req_vld;
  logic bus_req_rdy;
  logic bus_resp_last;

  modport slave (
    input  up_req_vld,
    input  bus_req_rdy,
    input  bus_resp_last,
    output up_req_rdy,
    output bus_req_vld
  );

  modport master (
    output up_req_vld,
    output bus_req_rdy,
    output bus_resp_last,
    input  up_req_rdy,
    input  bus_req_vld
  );

endinterface

// File: rtl/ct_biu_lpmd_outstd_cnt.sv
// Outstanding bus transaction counter (inc on issue, dec on last beat).
// Ports: clk_i, rst_i, inc_i, dec_i, cnt_zero_o, cnt_full_o.
module ct_biu_lpmd_outstd_cnt #(
  parameter int unsigned W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic cnt_zero_o,
  output logic cnt_full_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         inc;
  logic         dec;

  // A stray last beat with nothing in flight is dropped.
  assign inc = inc_i & (cnt_q != MAX);
  assign dec = dec_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_zero_o = (cnt_q == '0);
  assign cnt_full_o = (cnt_q == MAX);

endmodule

// File: rtl/ct_biu_lpmd_resp.sv
// BIU responder to the CP0 WFI no-op handshake: gate issue, drain, ack, track LPMD.
// Ports: forever_cpuclk, cpurst (sync, high), cp0_biu_no_op_req, cp0_biu_lpmd_b,
//   bus (handshake if), biu_yy_xx_no_op, biu_pad_lpmd_b, biu_lpmd_drain_tmo.
// Option: CT_BIU_LPMD_DRAIN_TMO_EN adds a drain watchdog pulse.
module ct_biu_lpmd_resp
  import ct_biu_lpmd_pkg::*;
#(
  parameter int unsigned OUTSTD_W  = 4,
  parameter int unsigned DRAIN_TMO = 1024
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cp0_biu_no_op_req,
  input  logic [1:0]        cp0_biu_lpmd_b,
  ct_biu_lpmd_resp_if.slave bus,
  output logic              biu_yy_xx_no_op,
  output logic [1:0]        biu_pad_lpmd_b,
  output logic              biu_lpmd_drain_tmo
);

  lpmd_st_e   state_q;
  lpmd_st_e   state_d;
  logic       ack_q;
  logic       ack_d;
  logic [1:0] pad_q;
  logic [1:0] pad_d;

  logic allow;
  logic issue;
  logic cnt_zero;
  logic cnt_full;
  logic lpmd_run;

  assign lpmd_run = (cp0_biu_lpmd_b == LPMD_RUN_B);

  // No_op_req blocks issue combinationally in the cycle it rises.
  assign allow = (state_q == ST_RUN) & ~cp0_biu_no_op_req & ~cnt_full;

  assign bus.bus_req_vld = allow & bus.up_req_vld;
  assign bus.up_req_rdy  = allow & bus.bus_req_rdy;
  assign issue           = bus.bus_req_vld & bus.bus_req_rdy;

  ct_biu_lpmd_outstd_cnt #(
    .W (OUTSTD_W)
  ) u_cnt (
    .clk_i      (forever_cpuclk),
    .rst_i      (cpurst),
    .inc_i      (issue),
    .dec_i      (bus.bus_resp_last),
    .cnt_zero_o (cnt_zero),
    .cnt_full_o (cnt_full)
  );

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    unique case (state_q)
      ST_RUN: begin
        if (cp0_biu_no_op_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A last beat taking cnt to zero is seen one cycle later.
        if (!cp0_biu_no_op_req)
          state_d = ST_RUN;
        else if (cnt_zero && !bus.bus_resp_last)
          state_d = ST_NOOP;
      end
      ST_NOOP: begin
        if (!cp0_biu_no_op_req) begin
          state_d = ST_RUN;
        end else if (!lpmd_run) begin
          state_d = ST_SLEEP;
          pad_d   = cp0_biu_lpmd_b;
        end
      end
      ST_SLEEP: begin
        // Wake wins over a still-raised no_op_req.
        if (lpmd_run) begin
          state_d = ST_RUN;
          pad_d   = LPMD_RUN_B;
        end
      end
      default: state_d = ST_RUN;
    endcase
    ack_d = (state_d == ST_NOOP) | (state_d == ST_SLEEP);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= ST_RUN;
      ack_q   <= 1'b0;
      pad_q   <= LPMD_RUN_B;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      pad_q   <= pad_d;
    end
  end

  assign biu_yy_xx_no_op = ack_q;
  assign biu_pad_lpmd_b  = pad_q;

`ifdef CT_BIU_LPMD_DRAIN_TMO_EN
  localparam int unsigned TW = $clog2(DRAIN_TMO + 1);

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;

  // Cleared outside DRAIN, so every DRAIN episode starts at zero;
  // saturates one past the pulse value to give a single pulse.
  always_comb begin
    tmr_d = '0;
    if (state_q == ST_DRAIN) begin
      if (tmr_q != TW'(DRAIN_TMO)) tmr_d = tmr_q + 1'b1;
      else                         tmr_d = tmr_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign biu_lpmd_drain_tmo = (state_q == ST_DRAIN) &
                              (tmr_q == TW'(DRAIN_TMO - 1));
`else
  logic drain_tmo_unused;
  assign drain_tmo_unused   = (DRAIN_TMO == 0);
  assign biu_lpmd_drain_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_ct_biu_lpmd_resp.sv
// Self-checking bench for ct_biu_lpmd_resp: vector table + scoreboard queue.
// Watchdog expectations follow CT_BIU_LPMD_DRAIN_TMO_EN.
module tb_ct_biu_lpmd_resp;

`ifdef CT_BIU_LPMD_DRAIN_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       nop;
  logic [1:0] lpmd;
  logic       ack;
  logic [1:0] pad;
  logic       tmo;

  ct_biu_lpmd_resp_if bif ();

  ct_biu_lpmd_resp #(
    .OUTSTD_W  (4),
    .DRAIN_TMO (8)
  ) dut (
    .forever_cpuclk     (clk),
    .cpurst             (rst),
    .cp0_biu_no_op_req  (nop),
    .cp0_biu_lpmd_b     (lpmd),
    .bus                (bif.slave),
    .biu_yy_xx_no_op    (ack),
    .biu_pad_lpmd_b     (pad),
    .biu_lpmd_drain_tmo (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       nop;
    bit [1:0] lpmd;
    bit       uv;
    bit       br;
    bit       rl;
    bit       bv;
    bit       ur;
    bit       ak;
    bit [1:0] pd;
    bit       ct;
    bit       et;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input bit r, input bit n, input bit [1:0] l,
                     input bit uv, input bit br, input bit rl,
                     input bit bv, input bit ur, input bit ak,
                     input bit [1:0] pd,
                     input bit ct = 1'b0, input bit et = 1'b0);
    vec_t v;
    v.rst = r;  v.nop = n; v.lpmd = l;
    v.uv = uv;  v.br = br; v.rl = rl;
    v.bv = bv;  v.ur = ur; v.ak = ak;
    v.pd = pd;  v.ct = ct; v.et = et;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0b want %0b", nm, idx, act, exp);
    end
  endtask

  task automatic idle_drain_rows();
    add(0,1,3,0,0,0, 0,0,0,3);
    add(0,1,3,0,0,0, 0,0,0,3);
    add(0,1,3,0,0,0, 0,0,1,3);
    add(0,0,3,0,0,0, 0,0,1,3);
    add(0,0,3,0,0,0, 0,0,0,3);
  endtask

  initial begin
    vec_t e;
    rst  = 1'b1;
    nop  = 1'b0;
    lpmd = 2'b11;
    bif.up_req_vld    = 1'b0;
    bif.bus_req_rdy   = 1'b0;
    bif.bus_resp_last = 1'b0;

    // reset pass-through, idle drain, sleep and wake
    add(0,0,3,1,0,0, 1,0,0,3);
    add(0,1,3,1,1,0, 0,0,0,3);
    add(0,1,3,1,1,0, 0,0,0,3);
    add(0,1,3,1,1,0, 0,0,1,3);
    add(0,1,0,0,0,0, 0,0,1,3);
    add(0,1,0,0,0,0, 0,0,1,0);
    add(0,0,0,1,1,0, 0,0,1,0);
    add(0,0,3,1,1,0, 0,0,1,0);
    add(0,0,3,1,0,0, 1,0,0,3);
    // busy drain: 3 issued, last beats at +5,+8,+12
    for (int k = 0; k < 3; k++) add(0,0,3,1,1,0, 1,1,0,3);
    add(0,1,3,1,1,0, 0,0,0,3);
    for (int k = 1; k <= 14; k++)
      add(0,1,3,1,1,(k==5 || k==8 || k==12), 0,0,(k==14),3);
    add(0,0,3,1,1,0, 0,0,1,3);
    add(0,0,3,1,0,0, 1,0,0,3);
    // flush with cnt=2
    for (int k = 0; k < 2; k++) add(0,0,3,1,1,0, 1,1,0,3);
    add(0,1,3,1,1,0, 0,0,0,3);
    add(0,1,3,1,1,0, 0,0,0,3);
    add(0,0,3,1,0,0, 0,0,0,3);
    add(0,0,3,1,0,0, 1,0,0,3);
    for (int k = 0; k < 2; k++) add(0,0,3,0,0,1, 0,0,0,3);
    idle_drain_rows();
    // counter edges
    add(0,0,3,1,1,0, 1,1,0,3);
    add(0,0,3,1,1,1, 1,1,0,3);
    add(0,0,3,0,0,1, 0,0,0,3);
    add(0,0,3,0,0,1, 0,0,0,3);
    for (int k = 0; k < 15; k++) add(0,0,3,1,1,0, 1,1,0,3);
    add(0,0,3,1,1,0, 0,0,0,3);
    add(0,0,3,1,1,1, 0,0,0,3);
    add(0,0,3,1,1,0, 1,1,0,3);
    add(0,0,3,1,1,0, 0,0,0,3);
    for (int k = 0; k < 15; k++) add(0,0,3,0,0,1, 0,0,0,3);
    idle_drain_rows();
    // wake precedence, then reset while asleep
    add(0,1,3,0,0,0, 0,0,0,3);
    add(0,1,3,0,0,0, 0,0,0,3);
    add(0,1,2,0,0,0, 0,0,1,3);
    add(0,1,2,0,0,0, 0,0,1,2);
    add(0,1,3,1,1,0, 0,0,1,2);
    add(0,1,3,1,1,0, 0,0,0,3);
    add(0,1,3,0,0,0, 0,0,0,3);
    add(0,1,1,0,0,0, 0,0,1,3);
    add(1,1,1,0,0,0, 0,0,1,1);
    add(0,0,3,1,0,0, 1,0,0,3);
    // reset discards in-flight count
    for (int k = 0; k < 3; k++) add(0,0,3,1,1,0, 1,1,0,3);
    add(1,0,3,0,0,0, 0,0,0,3);
    idle_drain_rows();
    // drain watchdog: one outstanding, no response for 20 cycles
    add(0,0,3,1,1,0, 1,1,0,3);
    add(0,1,3,0,0,0, 0,0,0,3, 1, 0);
    for (int k = 0; k < 20; k++)
      add(0,1,3,0,0,0, 0,0,0,3, 1, (TMO_ON && k == 7));
    add(0,1,3,0,0,1, 0,0,0,3, 1, 0);
    add(0,1,3,0,0,0, 0,0,0,3, 1, 0);
    add(0,1,3,0,0,0, 0,0,1,3, 1, 0);
    add(0,0,3,0,0,0, 0,0,1,3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    nop = 1'b1;
    lpmd = 2'b01;
    #1;
    chk("rst_ack", -1, {1'b0, ack}, 2'b00);
    chk("rst_pad", -1, pad, 2'b11);
    chk("rst_tmo", -1, {1'b0, tmo}, 2'b00);
    chk("rst_bv", -1, {1'b0, bif.bus_req_vld}, 2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst  = vq[i].rst;
      nop  = vq[i].nop;
      lpmd = vq[i].lpmd;
      bif.up_req_vld    = vq[i].uv;
      bif.bus_req_rdy   = vq[i].br;
      bif.bus_resp_last = vq[i].rl;
      sb.push_back(vq[i]);
      #1;
      e = sb.pop_front();
      chk("bus_req_vld", i, {1'b0, bif.bus_req_vld}, {1'b0, e.bv});
      chk("up_req_rdy", i, {1'b0, bif.up_req_rdy}, {1'b0, e.ur});
      chk("no_op_ack", i, {1'b0, ack}, {1'b0, e.ak});
      chk("pad_lpmd_b", i, pad, e.pd);
      if (e.ct) chk("drain_tmo", i, {1'b0, tmo}, {1'b0, e.et});
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
